alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_pipe_if.sv | 32 +++
 rtl/alu_core.sv | 55 +++++
 rtl/alu_pipe.sv | 54 +++++
 tb/tb_alu_pipe.sv | 124 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the alu_pipe slice.
//   DATA_W    - operand / result width (fixed at 8)
//   OP_W      - opcode width
//   alu_op_e  - 3-bit opcode encoding, OP_ADD .. OP_SHR
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/opcode request and result bundle for alu_pipe.
//   A, B     - unsigned operands
//   control  - opcode (alu_op_e encoding)
//   ALU_out  - registered result
//   Cout     - registered carry/flag
// Modports: master drives operands and reads results; slave is the ALU side.
interface alu_pipe_if;
    import alu_pkg::*;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [OP_W-1:0]   control;
    logic [DATA_W-1:0] ALU_out;
    logic              Cout;

    modport master (
        output A,
        output B,
        output control,
        input  ALU_out,
        input  Cout
    );

    modport slave (
        input  A,
        input  B,
        input  control,
        output ALU_out,
        output Cout
    );

endinterface : alu_pipe_if

// File: rtl/alu_core.sv
// alu_core: purely combinational 8-bit ALU.
//   a, b   - unsigned operands
//   op     - opcode
//   result - operation result (mod 256)
//   cout   - carry out for ADD/SUB, shifted-out bit for shifts, else 0
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    // One extra bit on each sum catches the carry out of bit 7.
    logic [DATA_W:0] sum_add;
    logic [DATA_W:0] sum_sub;

    // Subtraction as A + ~B + 1, so its carry means "no borrow" (A >= B).
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_add[DATA_W-1:0];
                cout   = sum_add[DATA_W];
            end
            OP_SUB: begin
                result = sum_sub[DATA_W-1:0];
                cout   = sum_sub[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                cout   = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                cout   = a[0];
            end
            default: begin
                result = '0;
                cout   = 1'b0;
            end
        endcase
    end

endmodule : alu_core

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined 8-bit ALU.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; clears both stages
//   bus    - alu_pipe_if.slave: A, B, control in; ALU_out, Cout out
// Inputs are registered on one edge, the alu_core result on the next, so a
// result appears two edges after its operands are sampled, one per cycle.
module alu_pipe
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);

    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    alu_op_e           s1_op;

    logic [DATA_W-1:0] core_result;
    logic              core_cout;

    // ---- stage 1: capture operands and opcode ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= OP_ADD;
        end else begin
            s1_a  <= bus.A;
            s1_b  <= bus.B;
            s1_op <= alu_op_e'(bus.control);
        end
    end

    alu_core u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result),
        .cout   (core_cout)
    );

    // ---- stage 2: register result and flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ALU_out <= '0;
            bus.Cout    <= 1'b0;
        end else begin
            bus.ALU_out <= core_result;
            bus.Cout    <= core_cout;
        end
    end

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge. Results are compared as {Cout, ALU_out}.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe_if bus ();

    alu_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cout=%b out=0x%h, expected cout=%b out=0x%h",
                     tag, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    function automatic logic [8:0] observed();
        return {bus.Cout, bus.ALU_out};
    endfunction

    // Apply a held vector and check the result on the second edge.
    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input alu_op_e op, input logic [7:0] res, input logic c);
        @(negedge clk);
        bus.A       = a;
        bus.B       = b;
        bus.control = op;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq(tag, observed(), {c, res});
    endtask

    logic [7:0] pa [8];
    logic [7:0] pb [8];
    alu_op_e    po [8];
    logic [8:0] pe [8];

    initial begin
        bus.A       = 8'h00;
        bus.B       = 8'h00;
        bus.control = OP_ADD;

        // Power-on reset: outputs clear immediately, without a clock edge.
        #1 rst_n = 1'b0;
        #1 check_eq("rst_async", observed(), 9'h000);
        repeat (2) @(posedge clk);
        #1 check_eq("rst_held", observed(), 9'h000);

        // Release with OR applied: first edge shows 0+0, second the OR.
        @(negedge clk);
        bus.A       = 8'd5;
        bus.B       = 8'd12;
        bus.control = OP_OR;
        rst_n       = 1'b1;
        @(posedge clk);
        #1 check_eq("or_edge1", observed(), 9'h000);
        @(posedge clk);
        #1 check_eq("or_edge2", observed(), {1'b0, 8'h0D});

        run_vec("sub_borrow",  8'd7,   8'd12,  OP_SUB, 8'hFB, 1'b0);
        run_vec("sub_noborrow",8'd12,  8'd7,   OP_SUB, 8'h05, 1'b1);
        run_vec("sub_equal",   8'h33,  8'h33,  OP_SUB, 8'h00, 1'b1);
        run_vec("add",         8'd6,   8'd10,  OP_ADD, 8'h10, 1'b0);
        run_vec("add_ovf",     8'd200, 8'd100, OP_ADD, 8'h2C, 1'b1);
        run_vec("add_wrap",    8'hFF,  8'h01,  OP_ADD, 8'h00, 1'b1);
        run_vec("shl",         8'h81,  8'h00,  OP_SHL, 8'h02, 1'b1);
        run_vec("shr",         8'h81,  8'hFF,  OP_SHR, 8'h40, 1'b1);
        run_vec("not",         8'h0F,  8'hAA,  OP_NOT, 8'hF0, 1'b0);
        run_vec("xor",         8'h3C,  8'h0F,  OP_XOR, 8'h33, 1'b0);
        run_vec("and",         8'h3C,  8'h0F,  OP_AND, 8'h0C, 1'b0);
        run_vec("add_pre_rst", 8'd200, 8'd100, OP_ADD, 8'h2C, 1'b1);

        // Mid-stream reset between edges, inputs still held at ADD 200+100.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_mid_async", observed(), 9'h000);
        @(posedge clk);
        #1 check_eq("rst_mid_held", observed(), 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("rst_rel_edge1", observed(), 9'h000);
        @(posedge clk);
        #1 check_eq("rst_rel_edge2", observed(), {1'b1, 8'h2C});

        // Back-to-back: a new vector every cycle, results in order 2 edges later.
        pa = '{8'h01, 8'h00, 8'hF0, 8'hA0, 8'hFF, 8'h55, 8'h40, 8'h02};
        pb = '{8'h02, 8'h01, 8'h3C, 8'h05, 8'h0F, 8'h12, 8'h00, 8'h00};
        po = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR};
        pe = '{9'h003, 9'h0FF, 9'h030, 9'h0A5, 9'h0F0, 9'h0AA, 9'h080, 9'h001};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 8) begin
                bus.A       = pa[i];
                bus.B       = pb[i];
                bus.control = po[i];
            end
            @(posedge clk);
            #1;
            if (i >= 1)
                check_eq($sformatf("pipe_%0d", i - 1), observed(), pe[i-1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_pipe
